// File: rtl/muladd_pkg.sv
// ---------------------------------------------------------------------------
// muladd_pkg
// Shared definitions for the round-robin multiply/add scheduler:
//   - sched_state_e : scheduler FSM states (IDLE, RUN, DRAIN)
//   - DEF_*         : default configuration constants
//   - id_width()    : requester-id width, $clog2 with a floor of one bit
//   - stage_t       : one pipeline stage {valid, id, a, b} at the default
//                     configuration (the pipe builds its own copy sized to
//                     its actual parameters)
// ---------------------------------------------------------------------------
package muladd_pkg;

   localparam int DEF_DATA_W  = 32;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_MUL_LAT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } sched_state_e;

   // A two-requester system still needs one id bit, which $clog2(2)
   // provides, but $clog2(1) would give zero; keep a one-bit floor.
   function automatic int id_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_ID_W = id_width(DEF_NUM_REQ);

   typedef struct packed {
      logic                  valid;
      logic [DEF_ID_W-1:0]   id;
      logic [DEF_DATA_W-1:0] a;
      logic [DEF_DATA_W-1:0] b;
   } stage_t;

endpackage

// File: rtl/muladd_pipe.sv
// ---------------------------------------------------------------------------
// muladd_pipe
// MUL_LAT-deep shift register of {valid, id, a, b} followed by an output
// register holding the truncated product and sum of the final stage.
// The whole pipe moves together on a single advance enable, which is true
// whenever the output register is empty or being consumed.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   load, load_id,        operand pair entering stage 0 on an advancing edge
//   load_a, load_b
//   advance               pipe shifts on the next edge
//   busy                  any stage or the output register holds an op
//   resp_valid/ready      output handshake
//   resp_id/mul/add       id, (a*b) mod 2^DATA_W, (a+b) mod 2^DATA_W
// ---------------------------------------------------------------------------
module muladd_pipe
   import muladd_pkg::*;
#(
   parameter int DATA_W  = DEF_DATA_W,
   parameter int ID_W    = 1,
   parameter int MUL_LAT = DEF_MUL_LAT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ID_W-1:0]   load_id,
   input  logic [DATA_W-1:0] load_a,
   input  logic [DATA_W-1:0] load_b,
   output logic              advance,
   output logic              busy,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [ID_W-1:0]   resp_id,
   output logic [DATA_W-1:0] resp_mul,
   output logic [DATA_W-1:0] resp_add
);

   typedef struct packed {
      logic              valid;
      logic [ID_W-1:0]   id;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
   } pipe_stage_t;

   logic [MUL_LAT-1:0] stage_valid;
   pipe_stage_t        tail;
   logic [DATA_W-1:0]  tail_mul;
   logic [DATA_W-1:0]  tail_add;

   // A held (unconsumed) result freezes every stage behind it.
   assign advance = !resp_valid || resp_ready;

   genvar gi;
   generate
      for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
         pipe_stage_t stage_next;
         pipe_stage_t stage_reg;

         if (gi == 0) begin : g_head
            assign stage_next = '{valid: load, id: load_id, a: load_a, b: load_b};
         end else begin : g_body
            assign stage_next = g_stage[gi-1].stage_reg;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stage_reg <= '0;
            end else if (advance) begin
               stage_reg <= stage_next;
            end
         end

         assign stage_valid[gi] = stage_reg.valid;
      end
   endgenerate

   assign tail = g_stage[MUL_LAT-1].stage_reg;

   // Results are DATA_W wide, so both operations wrap silently.
   assign tail_mul = tail.a * tail.b;
   assign tail_add = tail.a + tail.b;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resp_valid <= 1'b0;
         resp_id    <= '0;
         resp_mul   <= '0;
         resp_add   <= '0;
      end else if (advance) begin
         resp_valid <= tail.valid;
         // Bubbles leave the previous payload in place; only valid matters.
         if (tail.valid) begin
            resp_id  <= tail.id;
            resp_mul <= tail_mul;
            resp_add <= tail_add;
         end
      end
   end

   assign busy = (|stage_valid) || resp_valid;

endmodule

// File: rtl/muladd_rr_sched.sv
// ---------------------------------------------------------------------------
// muladd_rr_sched
// Shares one pipelined multiply/add datapath among NUM_REQ requesters with
// round-robin arbitration, and offers enable/drain/idle control so the
// surrounding harness can quiesce the datapath.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   enable                1 = accept new ops, 0 = drain
//   req_valid/req_ready   per-requester handshake (ready is one-hot or zero)
//   req_a, req_b          packed operands, requester i at [i*DATA_W +: DATA_W]
//   resp_valid/ready      result handshake
//   resp_id               originating requester
//   resp_mul, resp_add    (a*b) and (a+b), truncated to DATA_W
//   idle                  scheduler is in IDLE (pipeline empty)
//   op_count              accepted ops, wraps at 2^32
// ---------------------------------------------------------------------------
module muladd_rr_sched
   import muladd_pkg::*;
#(
   parameter  int NUM_REQ = DEF_NUM_REQ,
   parameter  int DATA_W  = DEF_DATA_W,
   parameter  int MUL_LAT = DEF_MUL_LAT,
   localparam int ID_W    = id_width(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      enable,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [ID_W-1:0]           resp_id,
   output logic [DATA_W-1:0]         resp_mul,
   output logic [DATA_W-1:0]         resp_add,
   output logic                      idle,
   output logic [31:0]               op_count
);

   sched_state_e      state_reg;
   logic [ID_W-1:0]   rr_ptr_reg;
   logic [31:0]       op_count_reg;

   logic              advance;
   logic              busy;
   logic              grant_en;
   logic              found;
   logic              handshake;
   logic [ID_W-1:0]   winner;
   int                cand;

   logic [DATA_W-1:0] a_lane [NUM_REQ];
   logic [DATA_W-1:0] b_lane [NUM_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_lane
         assign a_lane[gi] = req_a[gi*DATA_W +: DATA_W];
         assign b_lane[gi] = req_b[gi*DATA_W +: DATA_W];
      end
   endgenerate

   // Round-robin search starting at rr_ptr. The index is kept as an int
   // so NUM_REQ need not be a power of two; it never reaches NUM_REQ.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand = int'(rr_ptr_reg) + off;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
         if (!found && req_valid[cand[ID_W-1:0]]) begin
            found  = 1'b1;
            winner = cand[ID_W-1:0];
         end
      end
   end

   // Grants come from the registered state, so an op granted in the same
   // cycle that enable falls is still taken.
   assign grant_en  = (state_reg == RUN) && advance;
   assign handshake = grant_en && found;

   always_comb begin
      req_ready = '0;
      if (handshake) begin
         req_ready[winner] = 1'b1;
      end
   end

   muladd_pipe #(
      .DATA_W  (DATA_W),
      .ID_W    (ID_W),
      .MUL_LAT (MUL_LAT)
   ) u_pipe (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (handshake),
      .load_id    (winner),
      .load_a     (a_lane[winner]),
      .load_b     (b_lane[winner]),
      .advance    (advance),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_mul   (resp_mul),
      .resp_add   (resp_add)
   );

   // Pointer and counter move only on an accepted op; the pointer is
   // retained through DRAIN/IDLE so rotation resumes where it stopped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg   <= '0;
         op_count_reg <= '0;
      end else if (handshake) begin
         rr_ptr_reg   <= (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
         op_count_reg <= op_count_reg + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (enable) state_reg <= RUN;
            end
            RUN: begin
               if (!enable) state_reg <= DRAIN;
            end
            DRAIN: begin
               if (enable)     state_reg <= RUN;
               else if (!busy) state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign idle     = (state_reg == IDLE);
   assign op_count = op_count_reg;

endmodule

// File: tb/tb_muladd_rr_sched.sv
// ---------------------------------------------------------------------------
// tb_muladd_rr_sched
// Randomized requester agents drive the scheduler. A reference model tracks
// accepted ops as a queue stamped with the count of advancing clock edges:
// an op is visible at the output once LAT further advancing edges have
// passed, and the pipe only fails to advance while a result is held.
// Expected responses go into a scoreboard queue that a separate monitor
// drains whenever the DUT presents a result.
// ---------------------------------------------------------------------------
module tb_muladd_rr_sched;

   localparam int N   = 4;
   localparam int W   = 32;
   localparam int LAT = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           enable = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_a = '0;
   logic [N*W-1:0] req_b = '0;
   logic           resp_valid;
   logic           resp_ready = 1'b0;
   logic [1:0]     resp_id;
   logic [W-1:0]   resp_mul;
   logic [W-1:0]   resp_add;
   logic           idle;
   logic [31:0]    op_count;

   muladd_rr_sched #(.NUM_REQ(N), .DATA_W(W), .MUL_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_mul(resp_mul), .resp_add(resp_add),
      .idle(idle), .op_count(op_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // requester agents
   bit           pend [N];
   logic [W-1:0] pa [N];
   logic [W-1:0] pb [N];
   int req_pct = 0, rdy_pct = 100, en_pct = 0;

   // reference model
   typedef struct { int id; logic [W-1:0] a; logic [W-1:0] b; int stamp; } op_t;
   typedef struct { int id; logic [W-1:0] mul; logic [W-1:0] add; } resp_t;
   op_t   inflight [$];
   resp_t sb_q [$];
   int    m_state = 0;   // 0 idle, 1 run, 2 drain
   int    m_rr = 0;
   int    m_adv = 0;
   logic [31:0] m_ops = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rword();
      case ($urandom_range(3))
         0:       return '1;
         1:       return '0;
         default: return $urandom();
      endcase
   endfunction

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]       = pend[i];
         req_a[i*W +: W]    = pa[i];
         req_b[i*W +: W]    = pb[i];
      end
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && ($urandom_range(99) < req_pct)) begin
            pend[i] = 1'b1;
            pa[i]   = rword();
            pb[i]   = rword();
         end
      end
      apply();
      resp_ready = ($urandom_range(99) < rdy_pct);
      enable     = ($urandom_range(99) < en_pct);
   endtask

   // One clock cycle: check at the negedge, update the model at the
   // posedge, drive new inputs just after, return at the next negedge.
   task automatic step();
      bit           mv;
      bit           adv;
      bit           empty;
      int           w;
      logic [N-1:0] exp_rdy;
      logic [63:0]  full;
      resp_t        r;

      mv = (inflight.size() > 0) && (inflight[0].stamp + LAT <= m_adv);
      check("resp_valid", resp_valid, mv);
      check("idle", idle, (m_state == 0));
      check("op_count", op_count, m_ops);
      adv = !mv || resp_ready;
      w = -1;
      if (m_state == 1 && adv) begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (w < 0 && pend[j]) w = j;
         end
      end
      exp_rdy = '0;
      if (w >= 0) exp_rdy[w] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      empty = (inflight.size() == 0);

      @(posedge clk);
      if (mv && resp_ready) void'(inflight.pop_front());
      if (adv) begin
         m_adv++;
         if (w >= 0) begin
            inflight.push_back('{id: w, a: pa[w], b: pb[w], stamp: m_adv});
            full  = {32'b0, pa[w]} * {32'b0, pb[w]};
            r.id  = w;
            r.mul = full[W-1:0];
            r.add = pa[w] + pb[w];
            sb_q.push_back(r);
            m_rr  = (w + 1) % N;
            m_ops = m_ops + 32'd1;
            pend[w] = 1'b0;
         end
      end
      case (m_state)
         0: if (enable) m_state = 1;
         1: if (!enable) m_state = 2;
         default: begin
            if (enable) m_state = 1;
            else if (empty) m_state = 0;
         end
      endcase
      #1 drive();
      @(negedge clk);
   endtask

   // Monitor: compares every presented result against the scoreboard head
   // (so held results are checked every stalled cycle) and pops on accept.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && resp_valid) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL resp_unexpected: got id=%0d mul=0x%0h add=0x%0h, required no response", resp_id, resp_mul, resp_add);
            end else begin
               check("resp_id", resp_id, sb_q[0].id);
               check("resp_mul", resp_mul, sb_q[0].mul);
               check("resp_add", resp_add, sb_q[0].add);
               if (resp_ready) begin
                  $display("resp id=%0d mul=0x%08h add=0x%08h", resp_id, resp_mul, resp_add);
                  void'(sb_q.pop_front());
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b0; pa[i] = '0; pb[i] = '0;
      end
      apply();
      repeat (2) @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_resp_id", resp_id, 0);
      check("rst_resp_mul", resp_mul, 0);
      check("rst_resp_add", resp_add, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_idle", idle, 1);
      check("rst_op_count", op_count, 0);
      rst_n = 1'b1;

      // single op: req 0, 3*5 and 3+5
      pend[0] = 1'b1; pa[0] = 32'd3; pb[0] = 32'd5;
      en_pct = 100; rdy_pct = 100; req_pct = 0;
      enable = 1'b1; resp_ready = 1'b1;
      apply(); #1;
      repeat (8) step();
      check("single_op_count", op_count, 1);

      // fairness: every requester always valid
      req_pct = 100;
      for (int i = 0; i < N; i++) begin
         pend[i] = 1'b1; pa[i] = rword(); pb[i] = rword();
      end
      apply(); #1;
      repeat (12) step();

      // wrap-around operands
      req_pct = 0;
      repeat (6) step();
      pend[1] = 1'b1; pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd2;
      pend[3] = 1'b1; pa[3] = 32'h8000_0001; pb[3] = 32'hFFFF_FFFF;
      apply(); #1;
      repeat (8) step();

      // backpressure: fill, stall, release
      req_pct = 100;
      repeat (4) step();
      rdy_pct = 0;
      repeat (5) step();
      req_pct = 0; rdy_pct = 100;
      repeat (10) step();

      // drain with ops in flight, then re-enable
      pend[0] = 1'b1; pa[0] = rword(); pb[0] = rword();
      apply(); #1;
      step();
      pend[1] = 1'b1; pa[1] = rword(); pb[1] = rword();
      apply(); #1;
      en_pct = 0;
      step();
      for (int t = 0; t < 30 && m_state != 0; t++) step();
      check("drain_idle", idle, 1);
      pend[0] = 1'b1; pa[0] = rword(); pb[0] = rword();
      pend[2] = 1'b1; pa[2] = rword(); pb[2] = rword();
      en_pct = 100;
      apply(); #1;
      repeat (8) step();

      // randomized mix of requests, backpressure and enable toggling
      req_pct = 50; rdy_pct = 70; en_pct = 85;
      repeat (400) step();

      // reset with ops in flight
      req_pct = 100; rdy_pct = 100; en_pct = 100;
      repeat (4) step();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_resp_valid", resp_valid, 0);
      check("async_rst_idle", idle, 1);
      check("async_rst_req_ready", req_ready, 0);
      check("async_rst_op_count", op_count, 0);
      inflight.delete();
      sb_q.delete();
      m_state = 0; m_rr = 0; m_adv = 0; m_ops = '0;
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      req_pct = 0; en_pct = 0; enable = 1'b0;
      apply();
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(negedge clk);
      repeat (3) step();
      en_pct = 100;
      repeat (10) step();

      req_pct = 60; rdy_pct = 80;
      repeat (60) step();

      // final quiesce
      req_pct = 0; rdy_pct = 100; en_pct = 0;
      for (int t = 0; t < 40 && (m_state != 0 || inflight.size() != 0); t++) step();
      step();
      check("final_idle", idle, 1);
      check("leftover", sb_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
